// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller. It collects NUM_SRC external sources
// into the single registered interrupt request for the core. Each source has
// its own mask, edge/level mode and polarity. A claim register reports the
// lowest-index pending, enabled source.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_sel,
  input  logic               bus_ren,
  input  logic               bus_wen,
  input  logic [4:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               irq_out
);

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_MODE  = 3'd2;
  localparam logic [2:0] REG_POL   = 3'd3;
  localparam logic [2:0] REG_CLAIM = 3'd4;
  localparam logic [2:0] REG_RAW   = 3'd5;

  // Returns {valid, id}: the id of the lowest-index set request bit.
  function automatic logic [5:0] find_claim(input logic [NUM_SRC-1:0] req);
    logic [5:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

  logic [NUM_SRC-1:0] sync_p0, sync_p1, sync_p2;
  logic [NUM_SRC-1:0] pend, mask, mode, pol;
  logic [NUM_SRC-1:0] act, edge_det, clr, pend_next;
  logic [NUM_SRC-1:0] wr_bits;
  logic [5:0]         claim;
  logic               claim_vld;
  logic [4:0]         claim_id;
  logic               wr_acc, rd_acc, claim_rd;
  logic [2:0]         word;
  logic [31:0]        rd_mux;
  logic [31:0]        rdata_q;
  logic               irq_q;
  logic               unused_bits;

  assign wr_acc    = bus_sel & bus_wen;
  assign rd_acc    = bus_sel & bus_ren & ~bus_wen;
  assign word      = bus_addr[4:2];
  assign wr_bits   = bus_wdata[NUM_SRC-1:0];
  assign claim_rd  = rd_acc && (word == REG_CLAIM);

  // The byte lane bits and the data bits above the source count carry nothing.
  assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata[31:NUM_SRC]};

  // Two synchronizer flops, then a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= irq_src;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // ---- stage boundary: synchronized sources -> detection / pending ----
  // Polarity is applied to both the current sample and the history sample. A
  // change of polarity can therefore report one spurious edge.
  assign act       = sync_p1 ^ pol;
  assign edge_det  = act & ~(sync_p2 ^ pol);
  assign claim     = find_claim(pend & mask);
  assign claim_vld = claim[5];
  assign claim_id  = claim[4:0];

  // Clear requests for edge-mode bits, from a W1C write or an accepted claim.
  always_comb begin
    clr = '0;
    if (wr_acc && (word == REG_PEND)) clr = wr_bits;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim_rd && claim_vld && (claim_id == 5'(i))) clr[i] = 1'b1;
    end
  end

  // Edge bits: a set beats a clear in the same cycle. Level bits track the source.
  assign pend_next = (mode & (edge_det | (pend & ~clr))) | (~mode & act);

  // Pending state plus the software-visible configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
      pol  <= '0;
    end else begin
      pend <= pend_next;
      if (wr_acc) begin
        case (word)
          REG_MASK: mask <= wr_bits;
          REG_MODE: mode <= wr_bits;
          REG_POL:  pol  <= wr_bits;
          default:  ;
        endcase
      end
    end
  end

  // Read data comes from the state before this edge's updates.
  always_comb begin
    rd_mux = '0;
    case (word)
      REG_PEND:  rd_mux = 32'(pend);
      REG_MASK:  rd_mux = 32'(mask);
      REG_MODE:  rd_mux = 32'(mode);
      REG_POL:   rd_mux = 32'(pol);
      REG_CLAIM: rd_mux = {claim_vld, 26'b0, claim_id};
      REG_RAW:   rd_mux = 32'(sync_p1);
      default:   rd_mux = '0;
    endcase
  end

  // ---- stage boundary: registered bus read data and interrupt request ----
  // Read data holds between accepted reads. This gives the same one-cycle
  // latency as the synchronous data RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (rd_acc) rdata_q <= rd_mux;
      irq_q <= |(pend & mask);
    end
  end

  assign bus_rdata = rdata_q;
  assign irq_out   = irq_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller upstream of the MIPS core's single `interrupter` input; aggregates NUM_SRC external sources into one registered request line.
- Sits on the core's data-memory bus alongside data RAM; the top level decodes the address region and drives `bus_sel`.
- Per-source mask, edge/level mode and polarity; the ISR finds the highest-priority source through a claim register.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).

Ports:
- clk  in  1  main clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  raw, asynchronous interrupt inputs.
- bus_sel  in  1  address decode hit for this block's region.
- bus_ren  in  1  read enable (core mem_ren).
- bus_wen  in  1  write enable (core mem_wen).
- bus_addr  in  5  word-aligned byte offset, mem_addr[4:0]; bits [1:0] ignored.
- bus_wdata  in  32  write data (core mem_dout).
- bus_rdata  out  32  read data (to core mem_din mux).
- irq_out  out  1  interrupt request to core `interrupter`.

Behaviour:
- Reset (rst_n low, async): every flop cleared.
  - bus_rdata=0, irq_out=0.
  - PENDING=0, MASK=0, MODE=0, POL=0.
  - Synchronizer flops=0.
- Input path, per source:
  - Two-flop synchronizer s1→s2, plus history flop s3.
  - Active level a = s2 XOR POL[i].
  - Active edge e = (s2 XOR POL[i]) & ~(s3 XOR POL[i]).
  - When POL changes, history is compared under the new polarity, so a spurious edge is possible; software clears PENDING after changing POL.
- Register map (offset, access):
  - 0x00 PENDING R/W1C: 1 bits clear edge-mode pending; writes have no effect on level-mode bits.
  - 0x04 MASK RW: 1 enables the source.
  - 0x08 MODE RW: 1=edge, 0=level.
  - 0x0C POL RW: 1=active-low/falling, 0=active-high/rising.
  - 0x10 CLAIM R: {valid, 26'b0, id[4:0]}.
    - id = lowest index i with PENDING[i]&MASK[i]; valid=0 and id=0 if none.
    - Side effect: an accepted CLAIM read clears PENDING[id] if that source is edge-mode.
  - 0x14 RAW R: current s2 vector, zero-extended.
  - Other offsets: read 0, writes ignored.
  - Register bits above NUM_SRC read 0.
- PENDING update:
  - Level-mode bit: PENDING[i] <= a, every cycle.
  - Edge-mode bit: set on e; cleared by W1C or claim.
  - Set and clear in the same cycle: set wins.
  - Switching a source edge→level: the bit follows level next cycle. Switching level→edge: the bit holds its value until set/cleared.
- Bus handshake:
  - Access accepted only when bus_sel=1; bus_ren and bus_wen together: write wins, no read side effect.
  - Write: registers update on the accepting edge.
  - Read: bus_rdata registered, valid the cycle after bus_ren (matches synchronous RAM latency).
  - Read values reflect state before that edge's updates.
  - bus_rdata holds its last value when no read is accepted.
  - Consecutive reads every cycle are supported.
- irq_out:
  - Registered: irq_out <= |(PENDING & MASK[NUM_SRC-1:0]).
  - Input latency: irq_src change before edge 1 gives PENDING at edge 3 and irq_out at edge 4.
  - Mask or W1C changes reach irq_out one edge after the register update.
- No combinational path from any input to any output.

Test Plan:
- Reset and idle: rst_n low mid-traffic with irq_src=8'hFF.
  - All registers read 0; irq_out=0 within the same cycle as rst_n falling.
- Level path: MASK=8'h01, MODE=0, POL=0; raise irq_src[0] before an edge.
  - irq_out=1 exactly at the 4th rising edge.
  - Drop irq_src[0] → irq_out=0 four edges later.
  - W1C 0x01 while the source is high → PENDING stays 0x01.
- Edge path with claim: MODE=8'h0C, MASK=8'h0C; pulse irq_src[3] then irq_src[2] for 1 cycle each.
  - PENDING=0x0C.
  - CLAIM read → 0x80000002, then PENDING=0x08.
  - Second CLAIM read → 0x80000003, then irq_out drops.
  - Third CLAIM read → 0x00000000.
- Polarity: POL=8'h10, MODE=8'h10, MASK=8'h10; drive irq_src[4] from 1 to 0.
  - PENDING[4]=1; a 0→1 transition sets nothing.
- Simultaneous set/clear: an edge on source 1 reaches the detector in the same cycle as a W1C of 0x02.
  - PENDING[1]=1 after that edge.
- Bus corners:
  - Read 0x18 → 0.
  - Write 0x18 → no register change.
  - Write MASK=0xFFFFFFFF with NUM_SRC=8 → reads 0x000000FF.
  - Access with bus_sel=0 → no effect.
  - Simultaneous ren+wen to CLAIM → no pending cleared.
